// File: rtl/seq_addr_counter.sv
// Sequence address generator for the pattern ROM: start/busy/done protocol, round-limit clamp,
// one-cycle terminal-count pulse. Define SEQ_CNT_WRAP_EN to make a finished round restart at 0.
module seq_addr_counter #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned ROUND_MAX = 15
) (
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic              E,
    input  logic [ADDR_W-1:0] data,
    output logic [ADDR_W-1:0] SEQFPGA,
    output logic              tc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] remaining
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LIM_MAX = ROUND_MAX[ADDR_W-1:0];

    // Handshake: a one-cycle start is always accepted (it restarts any sequence in progress);
    // busy is high from the edge after start until the final step, then done stays high
    // until the next start or R. E only counts while busy; start beats E in the same cycle.
    logic [1:0]        state;
    logic [ADDR_W-1:0] lim;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] new_lim;

    assign new_lim = (data > LIM_MAX) ? LIM_MAX : data;

    always_ff @(posedge clk) begin
        if (R) begin
            state     <= IDLE;
            lim       <= '0;
            idx       <= '0;
            tc        <= 1'b0;
            remaining <= '0;
        end else begin
            tc <= 1'b0;
            if (start) begin
                state     <= RUN;
                lim       <= new_lim;
                idx       <= '0;
                remaining <= new_lim;
            end else if (state == RUN && E) begin
                if (idx == lim) begin
                    tc <= 1'b1;
`ifdef SEQ_CNT_WRAP_EN
                    idx       <= '0;
                    remaining <= lim;
`else
                    // idx deliberately holds at lim so the ROM keeps seeing the last address.
                    state     <= DONE;
                    remaining <= '0;
`endif
                end else begin
                    idx       <= idx + 1'b1;
                    remaining <= remaining - 1'b1;
                end
            end
        end
    end

    assign SEQFPGA = idx;
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_seq_addr_counter.sv
// Directed + random bench for seq_addr_counter (ADDR_W=4, ROUND_MAX=9); follows SEQ_CNT_WRAP_EN.
module tb_seq_addr_counter;

    localparam int W  = 4;
    localparam int RM = 9;
    localparam int EW = 2 * W + 3;

    logic         clk = 1'b0;
    logic         R = 1'b1, start = 1'b0, E = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] SEQFPGA, remaining;
    logic         tc, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int tc_count = 0;

    // expected {SEQFPGA, tc, busy, done, remaining}
    logic [EW-1:0] exp_q[$];

    // reference model state
    int unsigned m_idx = 0, m_lim = 0;
    logic        m_busy = 0, m_done = 0, m_tc = 0;

    seq_addr_counter #(.ADDR_W(W), .ROUND_MAX(RM)) dut (
        .clk(clk), .R(R), .start(start), .E(E), .data(data),
        .SEQFPGA(SEQFPGA), .tc(tc), .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic r, input logic s, input logic e, input logic [W-1:0] d);
        logic [W-1:0] rem;
        if (r) begin
            m_idx = 0; m_lim = 0; m_busy = 0; m_done = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (s) begin
                m_lim = (d > RM) ? RM : d;
                m_idx = 0; m_busy = 1; m_done = 0;
            end else if (m_busy && e) begin
                if (m_idx == m_lim) begin
                    m_tc = 1;
`ifdef SEQ_CNT_WRAP_EN
                    m_idx = 0;
`else
                    m_busy = 0; m_done = 1;
`endif
                end else begin
                    m_idx = m_idx + 1;
                end
            end
        end
        rem = m_busy ? W'(m_lim - m_idx) : '0;
        exp_q.push_back({W'(m_idx), m_tc, m_busy, m_done, rem});
    endtask

    // Drive one cycle, push the model's expectation, then pop/compare after the edge.
    task automatic cycle(input logic r, input logic s, input logic e, input logic [W-1:0] d);
        logic [EW-1:0] expv;
        R = r; start = s; E = e; data = d;
        model(r, s, e, d);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $error("FAIL scoreboard_empty: observed 0 expected 1");
        end else begin
            expv = exp_q.pop_front();
            check("seqfpga",   32'(SEQFPGA),   32'(expv[EW-1 -: W]));
            check("tc",        32'(tc),        32'(expv[W+2]));
            check("busy",      32'(busy),      32'(expv[W+1]));
            check("done",      32'(done),      32'(expv[W]));
            check("remaining", 32'(remaining), 32'(expv[W-1:0]));
        end
        if (tc === 1'b1) tc_count++;
    endtask

    task automatic steps(input int n, input logic e);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, e, '0);
    endtask

    initial begin
        // reset
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 7);
        check("reset_addr", 32'(SEQFPGA), 0);

        // normal round data=3: addresses 0..3, remaining 3..0, single tc
        cycle(0, 1, 0, 3);
        check("normal_start_rem", 32'(remaining), 3);
        tc_count = 0;
        steps(4, 1);
        steps(2, 1);
        check("normal_tc_pulses", 32'(tc_count), 1);
`ifndef SEQ_CNT_WRAP_EN
        check("normal_hold_addr", 32'(SEQFPGA), 3);
        check("normal_done", 32'(done), 1);
`endif

        // clamp: data=15 clamps to 9; 10th step is final, 12 steps give one tc either build
        cycle(0, 1, 0, 15);
        check("clamp_rem", 32'(remaining), 9);
        tc_count = 0;
        steps(12, 1);
        check("clamp_tc_pulses", 32'(tc_count), 1);
`ifdef SEQ_CNT_WRAP_EN
        check("clamp_addr", 32'(SEQFPGA), 2);
`else
        check("clamp_addr", 32'(SEQFPGA), 9);
`endif

        // simultaneous start+E at idx=2 restarts with no tc; E in DONE holds lim
        cycle(0, 1, 0, 7);
        steps(2, 1);
        tc_count = 0;
        cycle(0, 1, 1, 5);
        check("restart_addr", 32'(SEQFPGA), 0);
        check("restart_rem", 32'(remaining), 5);
        steps(6, 1);
        steps(3, 1);
        check("restart_tc_pulses", 32'(tc_count), 1);
`ifndef SEQ_CNT_WRAP_EN
        check("done_hold_addr", 32'(SEQFPGA), 5);
`endif

        // reset mid-run at idx=5, then E is ignored
        cycle(0, 1, 0, 9);
        steps(5, 1);
        check("pre_reset_addr", 32'(SEQFPGA), 5);
        cycle(1, 0, 1, 0);
        steps(3, 1);
        check("post_reset_addr", 32'(SEQFPGA), 0);

        // single-address round
        cycle(0, 1, 0, 0);
        tc_count = 0;
        steps(1, 1);
        check("single_tc", 32'(tc), 1);
        steps(1, 0);
        check("single_tc_pulses", 32'(tc_count), 1);

        // wrap demonstration: data=2, E high for 9 cycles
        cycle(0, 1, 0, 2);
        tc_count = 0;
        steps(9, 1);
`ifdef SEQ_CNT_WRAP_EN
        check("wrap_tc_pulses", 32'(tc_count), 3);
        check("wrap_busy", 32'(busy), 1);
`else
        check("nowrap_tc_pulses", 32'(tc_count), 1);
        check("nowrap_done", 32'(done), 1);
`endif

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 9) == 0),
                  logic'($urandom_range(0, 3) != 0), W'($urandom_range(0, 15)));
        end

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
